// File: rtl/vga_capture.sv
// VGA-side receiver: rebuilds a raster-ordered RGB444 pixel stream from sync/blank/RGB pins
// and flags line-length and line-count geometry errors against IMG_W x IMG_H.
module vga_capture #(
  parameter int   IMG_W       = 640,
  parameter int   IMG_H       = 480,
  parameter int   CLK_PER_PIX = 1,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        VGA_BLANK_N,
  input  logic        VGA_SYNC_N,
  output logic [11:0] pixel_out,
  output logic        out_ready,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        sof,
  output logic        eol,
  output logic        line_err,
  output logic        frame_err,
  output logic        locked
);

  localparam logic [10:0] RUN_FULL  = 11'(IMG_W);
  localparam logic [10:0] RUN_LAST  = 11'(IMG_W - 1);
  localparam logic [9:0]  LINE_FULL = 10'(IMG_H);
  localparam logic [2:0]  SUB_LAST  = 3'(CLK_PER_PIX - 1);
  localparam logic [2:0]  SUB_MID   = 3'(CLK_PER_PIX / 2);

  typedef enum logic [1:0] {S_SEEK, S_VBLANK, S_LINE, S_HBLANK} state_t;

  function automatic logic [10:0] sat_inc_run(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc_line(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vs_p0, r_vs_prev_p0, r_blank_p0, r_blank_prev_p0;
  logic [11:0] r_rgb_p0;
  logic [2:0]  r_sub;
  logic [10:0] r_run;
  logic [9:0]  r_line;
  logic        r_locked;
  logic        r_vld_p1, r_sof_p1, r_eol_p1, r_lerr_p1, r_ferr_p1;
  logic [11:0] r_pix_p1;
  logic [9:0]  r_x_p1;
  logic [8:0]  r_y_p1;

  logic        w_vs_assert, w_blank_rise, w_blank_fall;
  logic [2:0]  w_sub;
  logic [10:0] w_run;
  logic        w_in_line, w_take, w_emit;
  logic        w_line_err, w_frame_err, w_line_inc, w_line_clr, w_lock;
  logic        w_unused;

  // hsync and the low colour bits carry no information for the RGB444 stream
  assign w_unused = ^{hsync, VGA_SYNC_N, r[3:0], g[3:0], b[3:0]};

  // ---- stage p0: pin capture ----
  always_ff @(posedge clk) begin
    r_rgb_p0 <= {r[7:4], g[7:4], b[7:4]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_p0         <= ~SYNC_POL;
      r_vs_prev_p0    <= ~SYNC_POL;
      r_blank_p0      <= 1'b0;
      r_blank_prev_p0 <= 1'b0;
    end else begin
      r_vs_p0         <= vsync;
      r_vs_prev_p0    <= r_vs_p0;
      r_blank_p0      <= VGA_BLANK_N;
      r_blank_prev_p0 <= r_blank_p0;
    end
  end

  assign w_vs_assert  = (r_vs_p0 == SYNC_POL) && (r_vs_prev_p0 != SYNC_POL);
  assign w_blank_rise = r_blank_p0 && !r_blank_prev_p0;
  assign w_blank_fall = !r_blank_p0 && r_blank_prev_p0;

  // The first active cycle of a line is already a sampling candidate, before the state moves to LINE.
  assign w_sub     = w_blank_rise ? 3'd0 : r_sub;
  assign w_run     = w_blank_rise ? 11'd0 : r_run;
  assign w_in_line = !w_vs_assert &&
                     ((r_state == S_LINE) ||
                      (((r_state == S_VBLANK) || (r_state == S_HBLANK)) && w_blank_rise));
  assign w_take    = w_in_line && r_blank_p0 && (w_sub == SUB_MID);
  assign w_emit    = w_take && (w_run < RUN_FULL) && (r_line < LINE_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_line_err  = 1'b0;
    w_frame_err = 1'b0;
    w_line_inc  = 1'b0;
    w_line_clr  = 1'b0;
    w_lock      = 1'b0;
    case (r_state)
      S_SEEK: begin
        if (w_vs_assert) begin
          w_state_nxt = S_VBLANK;
          w_lock      = 1'b1;
          w_line_clr  = 1'b1;
        end
      end
      S_VBLANK, S_HBLANK: begin
        if (w_vs_assert) begin
          w_state_nxt = S_VBLANK;
          w_frame_err = (r_line != LINE_FULL);
          w_line_clr  = 1'b1;
        end else if (w_blank_rise) begin
          w_state_nxt = S_LINE;
        end
      end
      S_LINE: begin
        if (w_vs_assert) begin
          // aborted line is not counted toward the frame
          w_state_nxt = S_VBLANK;
          w_line_err  = 1'b1;
          w_frame_err = (r_line != LINE_FULL);
          w_line_clr  = 1'b1;
        end else if (w_blank_fall) begin
          w_state_nxt = S_HBLANK;
          w_line_err  = (r_run != RUN_FULL);
          w_line_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_SEEK;
    endcase
  end

  // ---- stage p1: sampling decision and output strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_SEEK;
      r_sub     <= 3'd0;
      r_run     <= 11'd0;
      r_line    <= 10'd0;
      r_locked  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_eol_p1  <= 1'b0;
      r_lerr_p1 <= 1'b0;
      r_ferr_p1 <= 1'b0;
      r_pix_p1  <= 12'd0;
      r_x_p1    <= 10'd0;
      r_y_p1    <= 9'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sub     <= (w_sub == SUB_LAST) ? 3'd0 : w_sub + 3'd1;
      r_run     <= w_take ? sat_inc_run(w_run) : w_run;
      if (w_line_clr)
        r_line <= 10'd0;
      else if (w_line_inc)
        r_line <= sat_inc_line(r_line);
      if (w_lock)
        r_locked <= 1'b1;
      r_vld_p1  <= w_emit;
      r_sof_p1  <= w_emit && (w_run == 11'd0) && (r_line == 10'd0);
      r_eol_p1  <= w_emit && (w_run == RUN_LAST);
      r_lerr_p1 <= w_line_err;
      r_ferr_p1 <= w_frame_err;
      if (w_emit) begin
        r_pix_p1 <= r_rgb_p0;
        r_x_p1   <= w_run[9:0];
        r_y_p1   <= r_line[8:0];
      end
    end
  end

  assign pixel_out = r_pix_p1;
  assign out_ready = r_vld_p1;
  assign x         = r_x_p1;
  assign y         = r_y_p1;
  assign sof       = r_sof_p1;
  assign eol       = r_eol_p1;
  assign line_err  = r_lerr_p1;
  assign frame_err = r_ferr_p1;
  assign locked    = r_locked;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: drives randomized VGA frames on shared pins into a 1-clk/pixel and a
// 2-clk/pixel instance; a frame-level model lists the expected strobes and error pulses.
module tb_vga_capture;
  localparam int W = 16;
  localparam int H = 8;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] pix;
    logic        sof;
    logic        eol;
  } strobe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, hsync, vsync, blank_n, sync_n;
  logic [7:0] r, g, b;

  logic [11:0] pix1, pix2;
  logic [9:0]  x1, x2;
  logic [8:0]  y1, y2;
  logic        rdy1, rdy2, sof1, sof2, eol1, eol2, le1_o, le2_o, fe1_o, fe2_o, lk1, lk2;

  vga_capture #(.IMG_W(W), .IMG_H(H), .CLK_PER_PIX(1), .SYNC_POL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .pixel_out(pix1), .out_ready(rdy1),
    .x(x1), .y(y1), .sof(sof1), .eol(eol1), .line_err(le1_o), .frame_err(fe1_o), .locked(lk1));

  vga_capture #(.IMG_W(W), .IMG_H(H), .CLK_PER_PIX(2), .SYNC_POL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .pixel_out(pix2), .out_ready(rdy2),
    .x(x2), .y(y2), .sof(sof2), .eol(eol2), .line_err(le2_o), .frame_err(fe2_o), .locked(lk2));

  // observed side
  strobe_t got1_q[$], got2_q[$];
  int      got2_cyc[$];
  int      le1 = 0, fe1 = 0, bad1 = 0, le2 = 0, fe2 = 0;
  int      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy1) got1_q.push_back(strobe_t'({x1, y1, pix1, sof1, eol1}));
    if (rdy2) begin
      got2_q.push_back(strobe_t'({x2, y2, pix2, sof2, eol2}));
      got2_cyc.push_back(cyc);
    end
    if (le1_o) le1++;
    if (fe1_o) fe1++;
    if ((sof1 || eol1) && !rdy1) bad1++;
    if (le2_o) le2++;
    if (fe2_o) fe2++;
  end

  // model side
  strobe_t exp_q[$];
  int      m_le = 0, m_fe = 0, m_lines = 0;
  bit      m_locked = 1'b0;
  int      g_cpp = 1;
  int      e_idx = 0, g_off = 0;
  int      n_total = 0, n_pass = 0;
  int      g2b, e2b, le2b, fe2b, mleb, mfeb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic bl, input logic vs, input logic hs, input logic [23:0] c);
    blank_n = bl;
    vsync   = vs;
    hsync   = hs;
    {r, g, b} = c;
    repeat (g_cpp) @(negedge clk);
  endtask

  task automatic hblank();
    int nb;
    nb = 3 + int'($urandom_range(3, 0));
    for (int i = 0; i < nb; i++) tick(1'b0, 1'b1, (i != 1), 24'h0);
  endtask

  // vsync: a frame closes (line count judged) and a new one opens
  task automatic vsync_evt();
    if (m_locked && (m_lines != H)) m_fe++;
    m_locked = 1'b1;
    m_lines  = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 24'h0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic active(input int len, input bit use_fix, input logic [23:0] fc);
    logic [23:0] c;
    strobe_t     s;
    for (int k = 0; k < len; k++) begin
      c = use_fix ? fc : 24'($urandom);
      if (m_locked && (m_lines < H) && (k < W)) begin
        s.x   = 10'(k);
        s.y   = 9'(m_lines);
        s.pix = {c[23:20], c[15:12], c[7:4]};
        s.sof = (m_lines == 0) && (k == 0);
        s.eol = (k == W - 1);
        exp_q.push_back(s);
      end
      tick(1'b1, 1'b1, 1'b1, c);
    end
  endtask

  task automatic line(input int len, input bit use_fix, input logic [23:0] fc);
    active(len, use_fix, fc);
    if (m_locked) begin
      if (len != W) m_le++;
      m_lines++;
    end
    hblank();
  endtask

  task automatic frame(input int nl, input int sp, input int splen);
    vsync_evt();
    for (int i = 0; i < nl; i++) line((i == sp) ? splen : W, 1'b0, 24'h0);
  endtask

  task automatic cmp1(input string tag);
    chk({tag, "_cnt"}, 64'(got1_q.size() - g_off), 64'(exp_q.size()));
    for (int i = e_idx; i < exp_q.size(); i++)
      if (i + g_off < got1_q.size())
        chk({tag, "_px"}, 64'(got1_q[i + g_off]), 64'(exp_q[i]));
    e_idx = exp_q.size();
    chk({tag, "_lerr"}, 64'(le1), 64'(m_le));
    chk({tag, "_ferr"}, 64'(fe1), 64'(m_fe));
    chk({tag, "_qual"}, 64'(bad1), 64'd0);
    chk({tag, "_lock"}, 64'(lk1), 64'(m_locked));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vsync = 1'b1; hsync = 1'b1; blank_n = 1'b0; sync_n = 1'b1;
    r = 8'h0; g = 8'h0; b = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(rdy1), 64'd0);
    chk("rst_x", 64'(x1), 64'd0);
    chk("rst_y", 64'(y1), 64'd0);
    chk("rst_pix", 64'(pix1), 64'd0);
    chk("rst_lock", 64'(lk1), 64'd0);
    chk("rst_flags", 64'({sof1, eol1, le1_o, fe1_o}), 64'd0);
    rst = 1'b0;

    // active video before any vsync is ignored
    line(W, 1'b0, 24'h0);
    cmp1("seek");

    frame(H, -1, 0);     cmp1("nominal");
    frame(H, 5, W - 1);  cmp1("short");
    frame(H, 3, W + 5);  cmp1("long");
    frame(H - 2, -1, 0); cmp1("fewlines");
    frame(H + 2, -1, 0); cmp1("extra");
    frame(H, -1, 0);     cmp1("after_err");

    // vsync arriving in the middle of an active line
    vsync_evt();
    for (int i = 0; i < 3; i++) line(W, 1'b0, 24'h0);
    active(5, 1'b0, 24'h0);
    if (m_locked) m_le++;
    vsync_evt();
    cmp1("abort");

    // reset in the middle of an active line
    for (int i = 0; i < 3; i++) line(W, 1'b0, 24'h0);
    cmp1("pre_rst");
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 24'($urandom));
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 24'($urandom));
    chk("mid_rst_rdy", 64'(rdy1), 64'd0);
    chk("mid_rst_lock", 64'(lk1), 64'd0);
    chk("mid_rst_xy", 64'({x1, y1}), 64'd0);
    rst = 1'b0;
    m_locked = 1'b0;
    m_lines  = 0;
    g_off    = got1_q.size() - exp_q.size();
    active(W - 6, 1'b0, 24'h0);
    hblank();
    for (int i = 0; i < 2; i++) line(W, 1'b0, 24'h0);
    cmp1("post_rst");
    frame(H, -1, 0);
    vsync_evt();
    cmp1("relock");

    // two clocks per pixel with a constant colour
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 24'h0);
    tick(1'b0, 1'b1, 1'b1, 24'h0);
    rst = 1'b0;
    chk("rst2_rdy", 64'(rdy2), 64'd0);
    chk("rst2_lock", 64'(lk2), 64'd0);
    m_locked = 1'b0;
    m_lines  = 0;
    g2b  = got2_q.size();
    e2b  = exp_q.size();
    le2b = le2;
    fe2b = fe2;
    mleb = m_le;
    mfeb = m_fe;
    g_cpp = 2;
    vsync_evt();
    for (int i = 0; i < H; i++) line(W, 1'b1, 24'hA5_3C_F0);
    vsync_evt();
    chk("cpp2_cnt", 64'(got2_q.size() - g2b), 64'(exp_q.size() - e2b));
    for (int i = 0; i < exp_q.size() - e2b; i++)
      if (g2b + i < got2_q.size())
        chk("cpp2_px", 64'(got2_q[g2b + i]), 64'(exp_q[e2b + i]));
    if (g2b < got2_q.size())
      chk("cpp2_colour", 64'(got2_q[g2b].pix), 64'h0A3F);
    for (int i = 1; i < W; i++)
      if (g2b + i < got2_cyc.size())
        chk("cpp2_gap", 64'(got2_cyc[g2b + i] - got2_cyc[g2b + i - 1]), 64'd2);
    chk("cpp2_lerr", 64'(le2 - le2b), 64'(m_le - mleb));
    chk("cpp2_ferr", 64'(fe2 - fe2b), 64'(m_fe - mfeb));
    chk("cpp2_lock", 64'(lk2), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
